// File: rtl/agmv_control_unit.sv
// Multi-cycle control FSM for the AGM-V 8-bit core: fetches a 3-byte command
// word through the MAR, decodes the path type, and sequences EXEC/WB/branch.
module agmv_control_unit #(
  parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  mem_data,
  input  logic        mem_ready,
  input  logic        cmp_eq,
  output logic        mar_load,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [7:0]  pc_target,
  output logic [23:0] command_word,
  output logic [7:0]  opcode_out,
  output logic [1:0]  path_type,
  output logic [5:0]  alu_op,
  output logic        alu_src_imm,
  output logic [7:0]  imm,
  output logic [7:0]  adr_1,
  output logic [7:0]  adr_2,
  output logic [7:0]  adr_3,
  output logic        reg_we,
  output logic        ready_reg_flag,
  output logic        halted,
  output logic [7:0]  state_out
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_FADDR  = 3'd1;
  localparam logic [2:0] S_FDATA  = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] cmd_q, cmd_d;

  logic [7:0] opcode;
  logic [7:0] byte1;
  logic [7:0] byte2;
  logic       branch_taken;

  assign opcode = cmd_q[23:16];
  assign byte1  = cmd_q[15:8];
  assign byte2  = cmd_q[7:0];

  // Memory handshake: in FDATA, mem_data is consumed on the rising edge where
  // mem_ready=1; while mem_ready=0 the FSM holds FDATA with every strobe low.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    cmd_d   = cmd_q;
    case (state_q)
      S_RESET: begin
        state_d = S_FADDR;
        bcnt_d  = 2'd0;
      end
      S_FADDR: state_d = S_FDATA;
      S_FDATA: begin
        if (mem_ready) begin
          case (bcnt_q)
            2'd0:    cmd_d[23:16] = mem_data;
            2'd1:    cmd_d[15:8]  = mem_data;
            default: cmd_d[7:0]   = mem_data;
          endcase
          if (bcnt_q < 2'd2) begin
            bcnt_d  = bcnt_q + 2'd1;
            state_d = S_FADDR;
          end else begin
            bcnt_d  = 2'd0;
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (opcode[7:6] == 2'b11) begin
          state_d = (opcode == HALT_OPCODE) ? S_HALT : S_FADDR;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC:  state_d = (opcode[7:6] == 2'b10) ? S_FADDR : S_WB;
      S_WB:    state_d = S_FADDR;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;
      bcnt_q  <= 2'd0;
      cmd_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      cmd_q   <= cmd_d;
    end
  end

  // Field decode is purely combinational; the command word is frozen from
  // DECODE through WB, so these fields are stable for the whole execution.
  always_comb begin
    adr_1       = 8'd0;
    adr_2       = 8'd0;
    adr_3       = 8'd0;
    imm         = 8'd0;
    pc_target   = 8'd0;
    alu_src_imm = 1'b0;
    case (opcode[7:6])
      2'b00: begin
        adr_3 = {4'd0, byte1[7:4]};
        adr_1 = {4'd0, byte1[3:0]};
        adr_2 = {4'd0, byte2[7:4]};
      end
      2'b01: begin
        adr_3       = {4'd0, byte1[7:4]};
        adr_1       = {4'd0, byte1[3:0]};
        imm         = byte2;
        alu_src_imm = 1'b1;
      end
      2'b10: begin
        adr_1     = {4'd0, byte1[3:0]};
        adr_2     = {4'd0, byte1[7:4]};
        pc_target = byte2;
      end
      default: ;
    endcase
  end

  assign branch_taken = (opcode[7:6] == 2'b10) && (!opcode[0] || cmp_eq);

  assign mar_load       = (state_q == S_FADDR);
  assign pc_inc         = (state_q == S_FDATA) && mem_ready;
  assign ir_load        = (state_q == S_FDATA) && mem_ready && (bcnt_q == 2'd0);
  assign pc_load        = (state_q == S_EXEC) && branch_taken;
  assign reg_we         = (state_q == S_WB);
  assign ready_reg_flag = (state_q == S_WB);
  assign halted         = (state_q == S_HALT);

  assign command_word = cmd_q;
  assign opcode_out   = opcode;
  assign path_type    = opcode[7:6];
  assign alu_op       = opcode[5:0];
  assign state_out    = {5'd0, state_q};

endmodule

// File: tb/tb_agmv_control_unit.sv
// Directed bench for agmv_control_unit: table of single-instruction vectors
// plus hand sequences for reset, HALT and reset during fetch.
module tb_agmv_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  mem_data;
  logic        mem_ready;
  logic        cmp_eq;
  logic        mar_load, ir_load, pc_inc, pc_load;
  logic [7:0]  pc_target;
  logic [23:0] command_word;
  logic [7:0]  opcode_out;
  logic [1:0]  path_type;
  logic [5:0]  alu_op;
  logic        alu_src_imm;
  logic [7:0]  imm, adr_1, adr_2, adr_3;
  logic        reg_we, ready_reg_flag, halted;
  logic [7:0]  state_out;

  agmv_control_unit #(.HALT_OPCODE(8'hFF)) dut (
    .clk(clk), .rst(rst), .mem_data(mem_data), .mem_ready(mem_ready),
    .cmp_eq(cmp_eq), .mar_load(mar_load), .ir_load(ir_load), .pc_inc(pc_inc),
    .pc_load(pc_load), .pc_target(pc_target), .command_word(command_word),
    .opcode_out(opcode_out), .path_type(path_type), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .imm(imm), .adr_1(adr_1), .adr_2(adr_2),
    .adr_3(adr_3), .reg_we(reg_we), .ready_reg_flag(ready_reg_flag),
    .halted(halted), .state_out(state_out)
  );

  // clock
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic        cmp;
    int          stall;
    logic [23:0] cw;
    logic [7:0]  a1, a2, a3, imm;
    logic        src;
    logic [5:0]  op;
    logic [1:0]  pt;
    int          len;
    logic        we;
    logic        pl;
    logic [7:0]  tgt;
    logic        chk_f;
  } vec_t;

  vec_t       vecs[7];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] cur_b[3];
  int         fidx;
  int         stall_left;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of the memory model: byte fidx is served, stalls only in the
  // second FDATA, and the served index advances whenever the DUT bumps PC.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    if (stall_left > 0 && state_out == 8'd2 && fidx == 1) begin
      mem_ready = 1'b0;
      stall_left--;
    end
    mem_data = (fidx < 3) ? cur_b[fidx] : 8'h00;
    #1;
    if (pc_inc) fidx++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fidx = 0;
  endtask

  initial begin
    int n_mar, n_ir, n_inc, n_we, n_pl, n_both, len, we_cyc;
    bit seen, done;
    rst = 1'b1; mem_data = 8'h00; mem_ready = 1'b0; cmp_eq = 1'b0;
    fidx = 0; stall_left = 0;
    cur_b[0] = 8'h00; cur_b[1] = 8'h00; cur_b[2] = 8'h00;

    //             b0     b1     b2    cmp st  cw            a1     a2     a3     imm    src  op     pt     len we   pl   tgt    chk_f
    vecs[0] = '{8'h02, 8'h31, 8'h20, 1'b0, 0, 24'h023120, 8'h01, 8'h02, 8'h03, 8'h00, 1'b0, 6'h02, 2'b00, 9,  1'b1, 1'b0, 8'h00, 1'b1};
    vecs[1] = '{8'h41, 8'h10, 8'h7F, 1'b0, 2, 24'h41107F, 8'h00, 8'h00, 8'h01, 8'h7F, 1'b1, 6'h01, 2'b01, 11, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'h81, 8'h21, 8'h40, 1'b1, 0, 24'h812140, 8'h01, 8'h02, 8'h00, 8'h00, 1'b0, 6'h01, 2'b10, 8,  1'b0, 1'b1, 8'h40, 1'b1};
    vecs[3] = '{8'h81, 8'h21, 8'h40, 1'b0, 0, 24'h812140, 8'h01, 8'h02, 8'h00, 8'h00, 1'b0, 6'h01, 2'b10, 8,  1'b0, 1'b0, 8'h40, 1'b1};
    vecs[4] = '{8'h80, 8'h5A, 8'h99, 1'b0, 0, 24'h805A99, 8'h0A, 8'h05, 8'h00, 8'h00, 1'b0, 6'h00, 2'b10, 8,  1'b0, 1'b1, 8'h99, 1'b1};
    vecs[5] = '{8'h3F, 8'hFE, 8'hDC, 1'b1, 0, 24'h3FFEDC, 8'h0E, 8'h0D, 8'h0F, 8'h00, 1'b0, 6'h3F, 2'b00, 9,  1'b1, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{8'hC5, 8'h12, 8'h34, 1'b0, 0, 24'hC51234, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 6'h05, 2'b11, 7,  1'b0, 1'b0, 8'h00, 1'b0};

    // Reset: two cycles held, everything zero, then FADDR with mar_load.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {24'd0, state_out}, 32'd0);
    check("reset_outs", {mar_load, ir_load, pc_inc, pc_load, reg_we, ready_reg_flag, halted,
                         pc_target, alu_src_imm, imm}, 32'd0);
    check("reset_fields", {command_word, adr_1}, 32'd0);
    check("reset_adr", {adr_2, adr_3, opcode_out, path_type, alu_op}, 32'd0);
    rst = 1'b0;
    fidx = 0;
    tick();
    check("release_state", {24'd0, state_out}, 32'd1);
    check("release_mar", {31'd0, mar_load}, 32'd1);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      cur_b[0] = vecs[v].b0; cur_b[1] = vecs[v].b1; cur_b[2] = vecs[v].b2;
      stall_left = vecs[v].stall;
      cmp_eq = vecs[v].cmp;
      n_mar = 0; n_ir = 0; n_inc = 0; n_we = 0; n_pl = 0; n_both = 0;
      len = 0; we_cyc = 0; seen = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
        tick();
        if (seen && state_out == 8'd1) begin
          done = 1;
        end else begin
          len++;
          if (mar_load) n_mar++;
          if (ir_load) n_ir++;
          if (pc_inc) n_inc++;
          if (pc_inc && pc_load) n_both++;
          if (reg_we) begin
            n_we++;
            we_cyc = len;
          end
          if (pc_load) begin
            n_pl++;
            check($sformatf("v%0d_pc_target", v), {24'd0, pc_target}, {24'd0, vecs[v].tgt});
          end
          if (state_out == 8'd3) begin
            seen = 1;
            check($sformatf("v%0d_cw", v), {8'd0, command_word}, {8'd0, vecs[v].cw});
            check($sformatf("v%0d_alu_op", v), {26'd0, alu_op}, {26'd0, vecs[v].op});
            check($sformatf("v%0d_path", v), {30'd0, path_type}, {30'd0, vecs[v].pt});
            if (vecs[v].chk_f) begin
              check($sformatf("v%0d_adr", v), {8'd0, adr_1, adr_2, adr_3},
                    {8'd0, vecs[v].a1, vecs[v].a2, vecs[v].a3});
              check($sformatf("v%0d_imm_src", v), {23'd0, alu_src_imm, imm},
                    {23'd0, vecs[v].src, vecs[v].imm});
            end
          end
        end
      end
      check($sformatf("v%0d_finished", v), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_cycles", v), len, vecs[v].len);
      check($sformatf("v%0d_pc_inc_cnt", v), n_inc, 3);
      check($sformatf("v%0d_mar_cnt", v), n_mar, 3);
      check($sformatf("v%0d_ir_cnt", v), n_ir, 1);
      check($sformatf("v%0d_inc_load_overlap", v), n_both, 0);
      check($sformatf("v%0d_reg_we_cnt", v), n_we, {31'd0, vecs[v].we});
      check($sformatf("v%0d_pc_load_cnt", v), n_pl, {31'd0, vecs[v].pl});
      if (vecs[v].we) check($sformatf("v%0d_we_cycle", v), we_cyc, vecs[v].len);
    end

    // HALT: decode FF, then sit in HALT with no strobes until reset.
    do_reset();
    cur_b[0] = 8'hFF; cur_b[1] = 8'h00; cur_b[2] = 8'h00;
    stall_left = 0; cmp_eq = 1'b1;
    repeat (7) tick();
    check("halt_decode_state", {24'd0, state_out}, 32'd3);
    for (int c = 0; c < 20; c++) begin
      tick();
      check("halt_hold", {18'd0, state_out, halted, mar_load, ir_load, pc_inc, pc_load, reg_we},
            {18'd0, 8'd6, 1'b1, 5'b0});
    end
    rst = 1'b1;
    tick();
    check("halt_reset_state", {24'd0, state_out}, 32'd0);
    check("halt_reset_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;

    // Reset asserted during the second FDATA restarts the fetch at byte 0.
    do_reset();
    cur_b[0] = 8'h02; cur_b[1] = 8'h31; cur_b[2] = 8'h20;
    stall_left = 0;
    repeat (4) tick();
    check("mid_second_fdata", {24'd0, state_out}, 32'd2);
    rst = 1'b1;
    tick();
    check("mid_reset_state", {24'd0, state_out}, 32'd0);
    check("mid_reset_cw", {8'd0, command_word}, 32'd0);
    rst = 1'b0;
    fidx = 0;
    tick();
    check("mid_restart_faddr", {24'd0, state_out}, 32'd1);
    tick();
    check("mid_restart_ir_load", {30'd0, ir_load, pc_inc}, 32'd3);
    tick();
    check("mid_restart_byte0", {8'd0, command_word}, 32'h00020000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
